// File: rtl/score_strobe_ctrl.sv
// score_strobe_ctrl
//   Time-multiplexed four-digit score display with high-score tracking.
//   A prescaler divides CLK into digit ticks. Each tick advances a 2-bit
//   digit index that cycles through:
//     0 = live units, 1 = live tens, 2 = high-score units, 3 = high-score tens.
//   The anode enables, the BCD digit value and the blank flag are registered
//   from the current index. Each GAME_OVER rising edge compares the live
//   score against the stored high score.
//
//   Optional feature: define SCORE_BLINK_EN to blink the high-score digits
//   while NEW_HIGH is set. The blink is driven by a BLINK_BITS-wide counter
//   that advances once per full strobe cycle.
//
// Ports
//   CLK          in   sole clock, rising edge
//   RESET        in   asynchronous, active-high reset
//   SCORE_UNITS  in   [3:0] live score units digit (BCD)
//   SCORE_TENS   in   [3:0] live score tens digit (BCD)
//   GAME_OVER    in   level, high while the game is over
//   STROBE_COUNT out  [1:0] current digit index
//   SEG_SELECT   out  [3:0] active-low anode enables, one-hot low
//   DIGIT_VALUE  out  [3:0] BCD value for the segment decoder
//   DIGIT_BLANK  out  high blanks the current digit
//   NEW_HIGH     out  high when the last game set a new high score
module score_strobe_ctrl #(
  parameter int STROBE_MAX = 99999,
  parameter int BLINK_BITS = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] SCORE_UNITS,
  input  logic [3:0] SCORE_TENS,
  input  logic       GAME_OVER,
  output logic [1:0] STROBE_COUNT,
  output logic [3:0] SEG_SELECT,
  output logic [3:0] DIGIT_VALUE,
  output logic       DIGIT_BLANK,
  output logic       NEW_HIGH
);

  localparam int PW = (STROBE_MAX < 1) ? 1 : $clog2(STROBE_MAX + 1);

  if (BLINK_BITS < 1) begin : g_bad_blink_bits
    $error("BLINK_BITS must be at least 1");
  end

  logic [PW-1:0] presc;
  logic          tick;
  logic [3:0]    units_c, tens_c;
  logic [3:0]    high_units, high_tens;
  logic          go_d;
  logic          go_rise, go_fall;
  logic          live_gt_high;
  logic          hs_blink;
  logic [3:0]    seg_nxt, value_nxt;
  logic          blank_nxt;

  assign tick    = (presc == PW'(STROBE_MAX));
  assign units_c = (SCORE_UNITS > 4'd9) ? 4'd9 : SCORE_UNITS;
  assign tens_c  = (SCORE_TENS  > 4'd9) ? 4'd9 : SCORE_TENS;
  assign go_rise = GAME_OVER & ~go_d;
  assign go_fall = ~GAME_OVER & go_d;
  // Clamped BCD digits order the same way as their decimal values.
  assign live_gt_high = {tens_c, units_c} > {high_tens, high_units};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      presc        <= '0;
      STROBE_COUNT <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) STROBE_COUNT <= STROBE_COUNT + 2'd1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      go_d       <= 1'b0;
      high_units <= '0;
      high_tens  <= '0;
      NEW_HIGH   <= 1'b0;
    end else begin
      go_d <= GAME_OVER;
      if (go_rise && live_gt_high) begin
        high_units <= units_c;
        high_tens  <= tens_c;
        NEW_HIGH   <= 1'b1;
      end else if (go_fall) begin
        NEW_HIGH <= 1'b0;
      end
    end
  end

`ifdef SCORE_BLINK_EN
  logic [BLINK_BITS-1:0] blink_cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) blink_cnt <= '0;
    else if (tick && STROBE_COUNT == 2'd3) blink_cnt <= blink_cnt + 1'b1;
  end

  assign hs_blink = NEW_HIGH & blink_cnt[BLINK_BITS-1];
`else
  assign hs_blink = 1'b0;
`endif

  always_comb begin
    seg_nxt   = 4'b1111;
    value_nxt = '0;
    blank_nxt = 1'b0;
    seg_nxt[STROBE_COUNT] = 1'b0;
    case (STROBE_COUNT)
      2'd0: value_nxt = units_c;
      2'd1: begin
        value_nxt = tens_c;
        blank_nxt = (tens_c == 4'd0);
      end
      2'd2: begin
        value_nxt = high_units;
        blank_nxt = hs_blink;
      end
      default: begin
        value_nxt = high_tens;
        blank_nxt = (high_tens == 4'd0) | hs_blink;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      SEG_SELECT  <= 4'b1110;
      DIGIT_VALUE <= '0;
      DIGIT_BLANK <= 1'b0;
    end else begin
      SEG_SELECT  <= seg_nxt;
      DIGIT_VALUE <= value_nxt;
      DIGIT_BLANK <= blank_nxt;
    end
  end

endmodule

// File: tb/tb_score_strobe_ctrl.sv
module tb_score_strobe_ctrl;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [3:0] SCORE_UNITS = '0;
  logic [3:0] SCORE_TENS = '0;
  logic       GAME_OVER = 1'b0;
  logic [1:0] STROBE_COUNT;
  logic [3:0] SEG_SELECT;
  logic [3:0] DIGIT_VALUE;
  logic       DIGIT_BLANK;
  logic       NEW_HIGH;

  int checks = 0;
  int errors = 0;

  // Reference model: edges since reset release, decimal high score,
  // new-high flag and the last GAME_OVER level seen at an edge.
  int k = 0;
  int high = 0;
  bit newh = 0;
  bit prev_go = 0;

  score_strobe_ctrl #(.STROBE_MAX(3), .BLINK_BITS(2)) dut (
    .CLK(CLK), .RESET(RESET), .SCORE_UNITS(SCORE_UNITS), .SCORE_TENS(SCORE_TENS),
    .GAME_OVER(GAME_OVER), .STROBE_COUNT(STROBE_COUNT), .SEG_SELECT(SEG_SELECT),
    .DIGIT_VALUE(DIGIT_VALUE), .DIGIT_BLANK(DIGIT_BLANK), .NEW_HIGH(NEW_HIGH)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_strobe"}, int'(STROBE_COUNT), 0);
    check({tag, "_seg"}, int'(SEG_SELECT), 4'b1110);
    check({tag, "_value"}, int'(DIGIT_VALUE), 0);
    check({tag, "_blank"}, int'(DIGIT_BLANK), 0);
    check({tag, "_newhigh"}, int'(NEW_HIGH), 0);
  endtask

  // One clock: apply inputs, predict the registered outputs, compare.
  task automatic step(input logic [3:0] u, input logic [3:0] t, input logic go);
    int idx, lu, lt, live, exp_val, exp_seg;
    bit exp_blank;
    SCORE_UNITS = u;
    SCORE_TENS  = t;
    GAME_OVER   = go;
    @(posedge CLK);
    idx  = (k / 4) % 4;
    lu   = clamp(u);
    lt   = clamp(t);
    live = 10 * lt + lu;
    exp_seg = 15 - (1 << idx);
    exp_blank = 0;
    case (idx)
      0: exp_val = lu;
      1: begin exp_val = lt; exp_blank = (lt == 0); end
      2: exp_val = high % 10;
      default: begin exp_val = high / 10; exp_blank = (high / 10 == 0); end
    endcase
`ifdef SCORE_BLINK_EN
    // High-score digits hidden on every other pair of full strobe cycles.
    if (idx >= 2 && newh && ((k / 32) % 2 == 1)) exp_blank = 1;
`endif
    if (go && !prev_go && live > high) begin
      high = live;
      newh = 1;
    end
    if (!go && prev_go) newh = 0;
    prev_go = go;
    k++;
    #1;
    check("strobe", int'(STROBE_COUNT), (k / 4) % 4);
    check("seg", int'(SEG_SELECT), exp_seg);
    check("value", int'(DIGIT_VALUE), exp_val);
    check("blank", int'(DIGIT_BLANK), int'(exp_blank));
    check("newhigh", int'(NEW_HIGH), int'(newh));
  endtask

  // Asynchronous reset applied between clock edges.
  task automatic mid_reset();
    #2 RESET = 1'b1;
    #1 check_reset_outputs("async_rst");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs("held_rst");
    RESET = 1'b0;
    k = 0; high = 0; newh = 0; prev_go = 0;
  endtask

  initial begin
    logic [3:0] ru, rt;
    logic rgo;
    #1 RESET = 1'b1;
    #1 check_reset_outputs("reset");
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;

    // Free-running strobe with GAME_OVER low.
    repeat (20) step(4'd5, 4'd0, 1'b0);

    // Score 07 ends a game: new high score, tens suppressed on index 3.
    repeat (40) step(4'd7, 4'd0, 1'b1);
    repeat (8) step(4'd7, 4'd0, 1'b0);

    // 42 sets the high score; an equal 42 and a lower 35 leave it alone.
    repeat (8) step(4'd2, 4'd4, 1'b0);
    repeat (8) step(4'd2, 4'd4, 1'b1);
    repeat (8) step(4'd2, 4'd4, 1'b0);
    repeat (8) step(4'd2, 4'd4, 1'b1);
    repeat (8) step(4'd5, 4'd3, 1'b0);
    repeat (20) step(4'd5, 4'd3, 1'b1);
    repeat (4) step(4'd5, 4'd3, 1'b0);

    // Out-of-range tens clamps to 9; compare uses 93.
    repeat (20) step(4'd3, 4'hC, 1'b0);
    repeat (20) step(4'd3, 4'hC, 1'b1);

    // Build high score 55 and reset while index 2 is being displayed.
    mid_reset();
    repeat (6) step(4'd5, 4'd5, 1'b0);
    repeat (4) step(4'd5, 4'd5, 1'b1);
    while (STROBE_COUNT != 2'd2) step(4'd5, 4'd5, 1'b1);
    step(4'd5, 4'd5, 1'b1);
    mid_reset();
    repeat (16) step(4'd0, 4'd0, 1'b0);

    // Long new-high hold so the blink period is exercised.
    repeat (150) step(4'd8, 4'd6, 1'b1);
    repeat (4) step(4'd8, 4'd6, 1'b0);

    // Randomized play with occasional resets.
    rgo = 1'b0;
    ru = '0;
    rt = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        ru = 4'($urandom_range(0, 15));
        rt = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 29) == 0) rgo = ~rgo;
      if ($urandom_range(0, 499) == 0) mid_reset();
      step(ru, rt, rgo);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_strobe_ctrl.md
SCORE_STROBE_CTRL -- requirements
Module: score_strobe_ctrl

Interface
REQ-001 SHALL have parameter STROBE_MAX, default 99999: prescaler terminal count; digit period is STROBE_MAX+1 CLK cycles.
REQ-002 SHALL have parameter BLINK_BITS, default 8: width of the blink counter, used only under SCORE_BLINK_EN.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port SCORE_UNITS  input  4  BCD units digit of the live score.
REQ-006 SHALL have port SCORE_TENS  input  4  BCD tens digit of the live score.
REQ-007 SHALL have port GAME_OVER  input  1  level; high while the game is over.
REQ-008 SHALL have port STROBE_COUNT  output  2  current digit index, 0..3.
REQ-009 SHALL have port SEG_SELECT  output  4  active-low digit anode enables, one-hot low.
REQ-010 SHALL have port DIGIT_VALUE  output  4  BCD value for the seven-segment decoder.
REQ-011 SHALL have port DIGIT_BLANK  output  1  high means the decoder drives all segments off.
REQ-012 SHALL have port NEW_HIGH  output  1  high when the last game set a new high score.

Function
REQ-013 Prescaler SHALL count 0..STROBE_MAX and wrap to 0; it SHALL assert an internal tick in the cycle the count equals STROBE_MAX.
REQ-014 STROBE_COUNT SHALL increment on each tick and wrap from 3 to 0.
REQ-015 Digit map SHALL be: index 0 = SCORE_UNITS, 1 = SCORE_TENS, 2 = high-score units, 3 = high-score tens.
REQ-016 SEG_SELECT, DIGIT_VALUE and DIGIT_BLANK SHALL be registered, updating exactly one CLK after STROBE_COUNT changes.
REQ-017 SEG_SELECT SHALL drive bit[STROBE_COUNT] low and the other three bits high.
REQ-018 Any input digit above 9 SHALL be clamped to 9 before display and comparison.
REQ-019 DIGIT_BLANK SHALL be high for index 1 when the live tens digit is 0, and for index 3 when the high-score tens digit is 0.
REQ-020 Units digits (indices 0 and 2) SHALL never be blanked by leading-zero suppression.
REQ-021 GAME_OVER SHALL be edge-detected through one internal register.
REQ-022 On a GAME_OVER rising edge, the clamped {tens,units} score SHALL be compared as an 8-bit unsigned value against the stored high score.
REQ-023 If the live score is strictly greater, the high score SHALL load it and NEW_HIGH SHALL set, both one cycle after the edge.
REQ-024 If the live score is equal or smaller, the high score SHALL be unchanged and NEW_HIGH SHALL remain 0.
REQ-025 NEW_HIGH SHALL clear on a GAME_OVER falling edge (start of a new game).
REQ-026 A GAME_OVER edge coinciding with a tick SHALL apply both; the high score change becomes visible at the next index-2/3 display.

Reset
REQ-027 RESET SHALL asynchronously clear the prescaler, STROBE_COUNT, high score, the GAME_OVER edge register and NEW_HIGH to 0.
REQ-028 During reset, outputs SHALL be SEG_SELECT=4'b1110, DIGIT_VALUE=0 and DIGIT_BLANK=0.
REQ-029 RESET asserted mid-digit or mid-game SHALL discard all state; the first tick after release SHALL occur at prescaler count STROBE_MAX.

Configuration
REQ-030 Macro SCORE_BLINK_EN defined: a BLINK_BITS-wide counter SHALL increment on each STROBE_COUNT wrap 3->0.
REQ-031 Macro SCORE_BLINK_EN defined: while NEW_HIGH=1 and the counter MSB=1, indices 2 and 3 SHALL be blanked.
REQ-032 Macro SCORE_BLINK_EN defined: the blink counter SHALL reset to 0.
REQ-033 Macro SCORE_BLINK_EN undefined: the blink counter SHALL not exist and the high-score digits SHALL never blink.

Verification (STROBE_MAX=3, BLINK_BITS=2)
REQ-034 Release reset, hold GAME_OVER=0 -> STROBE_COUNT steps 0,1,2,3,0 every 4 cycles; SEG_SELECT follows 1110,1101,1011,0111 one cycle later.
REQ-035 Score 0x07, GAME_OVER 0->1 -> high score becomes 07 and NEW_HIGH=1; index 3 DIGIT_BLANK=1, index 2 DIGIT_VALUE=7.
REQ-036 High score 42, score 0x42 then 0x35, GAME_OVER pulsed each time -> high score stays 42 and NEW_HIGH stays 0.
REQ-037 Score tens input 4'hC, units 3 -> index 1 DIGIT_VALUE=9; a game-over compare uses 93.
REQ-038 Assert RESET while index=2 with high score 55 -> immediately SEG_SELECT=1110, NEW_HIGH=0; index 2 then shows 0.
REQ-039 With SCORE_BLINK_EN defined and NEW_HIGH=1 -> indices 2/3 blank on alternate pairs of full strobe cycles; undefined -> never blank.
